// File: rtl/conv_mult_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_mult_arbiter_if
// Brief    : Requester, multiplier and response bundle for conv_mult_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_mult_arbiter_if #(
    parameter int WIDTH     = 32,
    parameter int NUM_REQ   = 2,
    parameter int TAG_DEPTH = 8
);
    // Requester operand side
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*2*WIDTH-1:0]   req_data;
    logic [NUM_REQ-1:0]           req_last;
    // Multiplier operand side
    logic                         mult_slv_valid;
    logic [1:0]                   mult_slv_ready;
    logic [2*WIDTH-1:0]           mult_slv_data;
    logic                         mult_slv_last;
    // Multiplier result side
    logic                         mult_mst_valid;
    logic                         mult_mst_ready;
    logic [WIDTH-1:0]             mult_mst_data;
    logic                         mult_mst_last;
    // Requester result side
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [NUM_REQ-1:0]           rsp_ready;
    logic [WIDTH-1:0]             rsp_data;
    logic                         rsp_last;
    logic [$clog2(TAG_DEPTH):0]   outstanding;

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last,
        output req_ready,
        output mult_slv_valid, mult_slv_data, mult_slv_last,
        input  mult_slv_ready,
        input  mult_mst_valid, mult_mst_data, mult_mst_last,
        output mult_mst_ready,
        output rsp_valid, rsp_data, rsp_last,
        input  rsp_ready,
        output outstanding
    );

    // Environment side (requesters + multiplier)
    modport master (
        output req_valid, req_data, req_last,
        input  req_ready,
        input  mult_slv_valid, mult_slv_data, mult_slv_last,
        output mult_slv_ready,
        output mult_mst_valid, mult_mst_data, mult_mst_last,
        input  mult_mst_ready,
        input  rsp_valid, rsp_data, rsp_last,
        output rsp_ready,
        input  outstanding
    );
endinterface
`default_nettype wire

// File: rtl/conv_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : conv_mult_arbiter
// Brief    : Packet-granular round-robin sharing of one AXIS multiplier, with
//            a tag FIFO that routes results back to the originating requester.
// Revision : 1.0 - initial release
// ============================================================================
module conv_mult_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NUM_REQ   = 2,
    parameter int TAG_DEPTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    conv_mult_arbiter_if.slave bus
);
    localparam int c_TAG_W = $clog2(NUM_REQ);
    localparam int c_PTR_W = $clog2(TAG_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]          r_state;
    logic [c_TAG_W-1:0]  r_grant;
    logic [c_TAG_W-1:0]  r_rr_ptr;
    logic [c_TAG_W-1:0]  r_tag_mem [TAG_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic                w_found;
    logic [c_TAG_W-1:0]  w_pick;
    logic [c_TAG_W-1:0]  w_cand;
    logic                w_full;
    logic                w_empty;
    logic                w_grant_go;
    logic                w_busy;
    logic                w_slv_rdy;
    logic                w_accept;
    logic                w_pkt_done;
    logic [c_TAG_W-1:0]  w_head;
    logic                w_pop;

    function automatic logic [c_TAG_W-1:0] f_offset(input logic [c_TAG_W-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % NUM_REQ;
        return sum[c_TAG_W-1:0];
    endfunction

    // Walk downward so the candidate closest to r_rr_ptr is the one kept.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = f_offset(r_rr_ptr, k);
            if (bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_full     = (r_count == c_CNT_W'(TAG_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_grant_go = (r_state == c_IDLE) && w_found && !w_full;
    assign w_busy     = (r_state == c_BUSY);
    assign w_slv_rdy  = &bus.mult_slv_ready;

    assign bus.mult_slv_valid = w_busy && bus.req_valid[r_grant];
    assign bus.mult_slv_data  = bus.req_data[int'(r_grant)*2*WIDTH +: 2*WIDTH];
    assign bus.mult_slv_last  = bus.req_last[r_grant];

    assign w_accept   = bus.mult_slv_valid && w_slv_rdy;
    assign w_pkt_done = w_accept && bus.req_last[r_grant];

    always_comb begin
        bus.req_ready = '0;
        if (w_busy) begin
            bus.req_ready[r_grant] = w_slv_rdy;
        end
    end

    // Results are held off entirely while no packet is outstanding.
    assign w_head = r_tag_mem[r_rd_ptr];

    always_comb begin
        bus.rsp_valid = '0;
        if (!w_empty) begin
            bus.rsp_valid[w_head] = bus.mult_mst_valid;
        end
    end

    assign bus.mult_mst_ready = !w_empty && bus.rsp_ready[w_head];
    assign bus.rsp_data       = bus.mult_mst_data;
    assign bus.rsp_last       = bus.mult_mst_last;
    assign w_pop              = bus.mult_mst_valid && bus.mult_mst_ready && bus.mult_mst_last;
    assign bus.outstanding    = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (r_state == c_IDLE) begin
                if (w_grant_go) begin
                    r_grant <= w_pick;
                    r_state <= c_BUSY;
                end
            end else begin
                if (w_pkt_done) begin
                    r_rr_ptr <= f_offset(r_grant, 1);
                    r_state  <= c_IDLE;
                end
            end

            if (w_grant_go) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_grant_go, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_grant_go) begin
            r_tag_mem[r_wr_ptr] <= w_pick;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_conv_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_mult_arbiter
// Brief    : Self-checking bench for conv_mult_arbiter with a packet-level
//            reference model, a multiplier model and directed corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_mult_arbiter;
    localparam int W = 16;
    localparam int N = 2;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_mult_arbiter_if #(.WIDTH(W), .NUM_REQ(N), .TAG_DEPTH(D)) bus ();

    conv_mult_arbiter #(.WIDTH(W), .NUM_REQ(N), .TAG_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct { int req; logic [W-1:0] a; logic [W-1:0] b; logic last; } beat_t;
    typedef struct { int req; logic [W-1:0] d; logic last; } res_t;
    typedef struct { logic [W-1:0] d; logic last; int avail; } pipe_t;
    typedef struct { int cyc; int req; logic last; } ev_t;
    typedef struct { logic [1:0] slv_rdy; logic [1:0] exp_req_ready; logic exp_valid; logic exp_last; } vec_t;

    beat_t sendq[$];
    res_t  expq[$];
    pipe_t pipe[$];
    ev_t   slv_log[$];
    ev_t   rsp_log[$];
    vec_t  tbl[9];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [N-1:0] en;
    int           lat_min, lat_max;
    bit           slv_rand, rsp_rand;
    logic [1:0]   slv_val;
    logic [N-1:0] rsp_val;

    int rr_model     = 0;
    bit in_pkt       = 1'b0;
    int owner        = 0;
    int last_end     = -100;
    int r1_first_rdy = -1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic load_pkt(input int r, input int len);
        beat_t bt;
        res_t  rs;
        for (int i = 0; i < len; i++) begin
            bt.req  = r;
            bt.a    = W'($urandom);
            bt.b    = W'($urandom);
            bt.last = (i == len - 1);
            sendq.push_back(bt);
            rs.req  = r;
            rs.d    = bt.a * bt.b;
            rs.last = bt.last;
            expq.push_back(rs);
        end
    endtask

    function automatic int find_send(input int r);
        for (int k = 0; k < sendq.size(); k++) if (sendq[k].req == r) return k;
        return -1;
    endfunction

    function automatic int find_exp(input int r);
        for (int k = 0; k < expq.size(); k++) if (expq[k].req == r) return k;
        return -1;
    endfunction

    // Round-robin rule: first requester with a pending packet after the last winner.
    function automatic int exp_winner();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (rr_model + k) % N;
            if (en[j] && find_send(j) >= 0) return j;
        end
        return -1;
    endfunction

    task automatic apply();
        int          k;
        logic [31:0] rnd;
        for (int i = 0; i < N; i++) begin
            k = find_send(i);
            bus.req_valid[i] = en[i] && (k >= 0);
            if (k >= 0) begin
                bus.req_data[i*2*W +: 2*W] = {sendq[k].a, sendq[k].b};
                bus.req_last[i]            = sendq[k].last;
            end else begin
                bus.req_data[i*2*W +: 2*W] = '0;
                bus.req_last[i]            = 1'b0;
            end
        end
        rnd = $urandom;
        bus.mult_slv_ready = slv_rand ? rnd[1:0] : slv_val;
        rnd = $urandom;
        bus.rsp_ready = rsp_rand ? rnd[N-1:0] : rsp_val;
        if (pipe.size() > 0 && pipe[0].avail <= cyc) begin
            bus.mult_mst_valid = 1'b1;
            bus.mult_mst_data  = pipe[0].d;
            bus.mult_mst_last  = pipe[0].last;
        end else begin
            bus.mult_mst_valid = 1'b0;
            bus.mult_mst_data  = '0;
            bus.mult_mst_last  = 1'b0;
        end
    endtask

    task automatic observe();
        int           nf, fr, k, r, w;
        bit           sfire, mfire;
        logic [N-1:0] rf;
        pipe_t        pe;
        ev_t          ev;

        chk("req_ready_onehot0", ($countones(bus.req_ready) <= 1), 1);
        if (bus.req_ready[1] && r1_first_rdy < 0) r1_first_rdy = cyc;

        nf = 0;
        fr = -1;
        for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                nf++;
                fr = i;
            end
        end
        sfire = bus.mult_slv_valid && (&bus.mult_slv_ready);
        if (sfire || nf != 0) chk("slv_fire_vs_req_fire", nf, sfire);
        if (sfire && nf == 1) begin
            k = find_send(fr);
            chk("slv_beat", {bus.mult_slv_last, bus.mult_slv_data}, {sendq[k].last, sendq[k].a, sendq[k].b});
            if (!in_pkt) begin
                w = exp_winner();
                chk("rr_winner", fr, w);
                chk("bubble_before_packet", ((cyc - last_end) >= 2), 1);
                in_pkt = 1'b1;
                owner  = fr;
            end else begin
                chk("pkt_owner", fr, owner);
            end
            if (sendq[k].last) begin
                in_pkt   = 1'b0;
                rr_model = (fr + 1) % N;
                last_end = cyc;
            end
            pe.d     = bus.mult_slv_data[2*W-1:W] * bus.mult_slv_data[W-1:0];
            pe.last  = bus.mult_slv_last;
            pe.avail = cyc + $urandom_range(lat_max, lat_min);
            pipe.push_back(pe);
            ev.cyc  = cyc;
            ev.req  = fr;
            ev.last = sendq[k].last;
            slv_log.push_back(ev);
            sendq.delete(k);
        end

        rf    = bus.rsp_valid & bus.rsp_ready;
        mfire = bus.mult_mst_valid && bus.mult_mst_ready;
        if (bus.mult_mst_valid) chk("rsp_route_fire", $countones(rf), mfire);
        else                    chk("rsp_valid_idle", bus.rsp_valid, 0);
        if (mfire && $countones(rf) == 1) begin
            r = 0;
            for (int i = 0; i < N; i++) if (rf[i]) r = i;
            k = find_exp(r);
            if (k < 0) begin
                chk("rsp_unexpected", r + 1, 0);
            end else begin
                chk("rsp_result", {bus.rsp_last, bus.rsp_data}, {expq[k].last, expq[k].d});
                expq.delete(k);
            end
            ev.cyc  = cyc;
            ev.req  = r;
            ev.last = bus.rsp_last;
            rsp_log.push_back(ev);
        end
        if (mfire && pipe.size() > 0) void'(pipe.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        apply();
        @(negedge clk);
        observe();
        cyc++;
    endtask

    task automatic drain(input string name, input int budget);
        for (int t = 0; t < budget && !(sendq.size() == 0 && expq.size() == 0 && pipe.size() == 0); t++) tick();
        chk(name, (sendq.size() == 0 && expq.size() == 0 && pipe.size() == 0), 1);
    endtask

    task automatic clear_logs();
        slv_log.delete();
        rsp_log.delete();
    endtask

    initial begin
        // Operand-stall table: {mult_slv_ready, expected req_ready, expected valid, expected last}
        tbl[0] = '{2'b00, 2'b00, 1'b1, 1'b0};
        tbl[1] = '{2'b01, 2'b00, 1'b1, 1'b0};
        tbl[2] = '{2'b10, 2'b00, 1'b1, 1'b0};
        tbl[3] = '{2'b11, 2'b01, 1'b1, 1'b0};
        tbl[4] = '{2'b01, 2'b00, 1'b1, 1'b0};
        tbl[5] = '{2'b11, 2'b01, 1'b1, 1'b0};
        tbl[6] = '{2'b10, 2'b00, 1'b1, 1'b1};
        tbl[7] = '{2'b01, 2'b00, 1'b1, 1'b1};
        tbl[8] = '{2'b11, 2'b01, 1'b1, 1'b1};

        rst      = 1'b1;
        en       = '1;
        lat_min  = 1;
        lat_max  = 1;
        slv_rand = 1'b0;
        rsp_rand = 1'b0;
        slv_val  = 2'b11;
        rsp_val  = '1;

        // Reset with both requesters already presenting packets
        load_pkt(0, 3); load_pkt(1, 3); load_pkt(0, 3); load_pkt(1, 3);
        apply();
        for (int t = 0; t < 2; t++) begin
            tick();
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_slv_valid", bus.mult_slv_valid, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_mst_ready", bus.mult_mst_ready, 0);
            chk("rst_outstanding", bus.outstanding, 0);
        end
        chk("rst_no_grant", slv_log.size(), 0);
        rst = 1'b0;

        // Round robin with 3-beat packets
        drain("rr_drain", 300);
        chk("rr_beats", slv_log.size(), 12);
        if (slv_log.size() == 12) begin
            for (int p = 0; p < 4; p++) begin
                chk("rr_grant_order", slv_log[3*p].req, p % 2);
                chk("rr_beat1_next", slv_log[3*p+1].cyc, slv_log[3*p].cyc + 1);
                chk("rr_beat2_next", slv_log[3*p+2].cyc, slv_log[3*p].cyc + 2);
                chk("rr_last_pos", slv_log[3*p+2].last, 1);
                if (p > 0) chk("rr_idle_gap", slv_log[3*p].cyc, slv_log[3*p-1].cyc + 2);
            end
        end

        // Packet lock: req1 shows up mid-way through req0's 4-beat packet
        clear_logs();
        en = 2'b01;
        r1_first_rdy = -1;
        load_pkt(0, 4);
        load_pkt(1, 2);
        for (int t = 0; t < 50 && slv_log.size() < 2; t++) tick();
        chk("lock_wait", (slv_log.size() >= 2), 1);
        en = 2'b11;
        drain("lock_drain", 200);
        chk("lock_beats", slv_log.size(), 6);
        if (slv_log.size() == 6) begin
            chk("lock_r0_owner", slv_log[3].req, 0);
            chk("lock_r0_last", slv_log[3].last, 1);
            chk("lock_r1_grant", slv_log[4].req, 1);
            chk("lock_r1_gap", slv_log[4].cyc, slv_log[3].cyc + 2);
            chk("lock_r1_first_ready", r1_first_rdy, slv_log[3].cyc + 2);
        end

        // Response routing through a 5-cycle multiplier
        clear_logs();
        lat_min = 5;
        lat_max = 5;
        load_pkt(0, 2);
        for (int t = 0; t < 50 && slv_log.size() < 1; t++) tick();
        chk("route_wait", (slv_log.size() >= 1), 1);
        load_pkt(1, 3);
        drain("route_drain", 200);
        chk("route_count", rsp_log.size(), 5);
        if (rsp_log.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("route_req", rsp_log[i].req, (i < 2) ? 0 : 1);
                chk("route_last", rsp_log[i].last, (i == 1 || i == 4) ? 1 : 0);
            end
        end

        // Tag FIFO full with results backpressured
        clear_logs();
        lat_min = 1;
        lat_max = 1;
        rsp_val = 2'b00;
        load_pkt(0, 1); load_pkt(0, 1); load_pkt(0, 1);
        for (int t = 0; t < 50 && bus.outstanding != 2; t++) tick();
        chk("full_wait", bus.outstanding, 2);
        for (int t = 0; t < 8; t++) tick();
        chk("full_outstanding", bus.outstanding, 2);
        chk("full_no_third", slv_log.size(), 2);
        chk("full_mst_ready", bus.mult_mst_ready, 0);
        chk("full_rsp_valid", bus.rsp_valid, 2'b01);
        rsp_val = 2'b01;
        for (int t = 0; t < 10 && rsp_log.size() < 1; t++) tick();
        chk("full_pop_wait", (rsp_log.size() >= 1), 1);
        for (int t = 0; t < 20 && slv_log.size() < 3; t++) tick();
        chk("full_third_wait", (slv_log.size() >= 3), 1);
        if (slv_log.size() >= 3 && rsp_log.size() >= 1)
            chk("full_third_grant", slv_log[2].cyc, rsp_log[0].cyc + 2);
        rsp_val = 2'b11;
        drain("full_drain", 100);

        // Operand stall, table-driven
        clear_logs();
        slv_val = 2'b00;
        load_pkt(0, 3);
        for (int t = 0; t < 20 && !bus.mult_slv_valid; t++) tick();
        chk("stall_wait", bus.mult_slv_valid, 1);
        for (int i = 0; i < 9; i++) begin
            slv_val = tbl[i].slv_rdy;
            tick();
            chk("stall_req_ready", bus.req_ready, tbl[i].exp_req_ready);
            chk("stall_valid", bus.mult_slv_valid, tbl[i].exp_valid);
            chk("stall_last", bus.mult_slv_last, tbl[i].exp_last);
        end
        slv_val = 2'b11;
        drain("stall_drain", 100);
        chk("stall_beats", slv_log.size(), 3);

        // Randomized traffic against the packet-level model
        clear_logs();
        slv_rand = 1'b1;
        rsp_rand = 1'b1;
        lat_min  = 1;
        lat_max  = 6;
        for (int p = 0; p < 80; p++) load_pkt($urandom_range(N - 1, 0), $urandom_range(4, 1));
        drain("random_drain", 20000);
        tick();
        chk("final_outstanding", bus.outstanding, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete, got cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/conv_mult_arbiter.md
Name: conv_mult_arbiter

Overview:
- Shares one AXIS multiplier between NUM_REQ convolution input requesters, for example several conv_input instances.
- Arbitrates round-robin at packet granularity. Once a requester wins, it holds the multiplier until its tlast beat is accepted.
- Records the winning requester index per packet in a tag FIFO. Multiplier results are routed back to the originating requester's response port in order.
- Sits between the conv_input instances, the mult core and the conv_output instances.

Parameters:
- WIDTH, 32, operand and result word width.
- NUM_REQ, 2, number of requesters (2..8).
- TAG_DEPTH, 8, maximum packets outstanding in the multiplier (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester operand ready.
- req_data  in  NUM_REQ*2*WIDTH  per-requester {a,b} operands; requester i occupies slice i.
- req_last  in  NUM_REQ  per-requester packet end.
- mult_slv_valid  out  1  drives both multiplier a and b tvalid.
- mult_slv_ready  in  2  {b_tready, a_tready}.
- mult_slv_data  out  2*WIDTH  {a,b} to multiplier.
- mult_slv_last  out  1  drives both multiplier a and b tlast.
- mult_mst_valid  in  1  result valid.
- mult_mst_ready  out  1  result ready.
- mult_mst_data  in  WIDTH  result.
- mult_mst_last  in  1  result packet end.
- rsp_valid  out  NUM_REQ  per-requester result valid.
- rsp_ready  in  NUM_REQ  per-requester result ready.
- rsp_data  out  WIDTH  result data, broadcast to all requesters.
- rsp_last  out  1  result last, broadcast.
- outstanding  out  $clog2(TAG_DEPTH)+1  packets currently in tag FIFO.

Behaviour:
- Reset (synchronous, active-high; clk and rst as named above):
  - state=IDLE, grant=0, rr_ptr=0, tag FIFO empty, outstanding=0.
  - All req_ready, mult_slv_valid, rsp_valid and mult_mst_ready are 0.
- FSM states are IDLE and BUSY.
- IDLE:
  - If any req_valid and tag FIFO not full, pick the first set req_valid searching upward from rr_ptr, with modulo-NUM_REQ wrap.
  - Register that index into grant, push it into the tag FIFO, then go to BUSY next cycle.
  - In IDLE, req_ready=0 and mult_slv_valid=0, which gives one bubble cycle per packet.
  - If the tag FIFO is full, stay in IDLE and make no grant, even if a pop occurs in the same cycle. A pop frees the slot for the next cycle.
- BUSY:
  - Combinational pass-through from requester grant:
    - mult_slv_valid = req_valid[grant]
    - mult_slv_data = req_data slice grant
    - mult_slv_last = req_last[grant]
    - req_ready[grant] = mult_slv_ready[0] & mult_slv_ready[1]
    - All other req_ready bits are 0.
  - A beat is accepted when mult_slv_valid and both readies are high.
  - When the accepted beat has last=1, set rr_ptr=(grant+1) mod NUM_REQ and return to IDLE the next cycle.
  - grant never changes mid-packet.
- Response routing uses head = tag FIFO front.
  - When the FIFO is not empty:
    - rsp_valid[head] = mult_mst_valid; other rsp_valid bits are 0.
    - mult_mst_ready = rsp_ready[head].
  - When the FIFO is empty, mult_mst_ready=0 and all rsp_valid are 0, so results are backpressured and never dropped.
  - rsp_data=mult_mst_data and rsp_last=mult_mst_last combinationally.
  - The FIFO pops when a result beat with last=1 is accepted.
- Tag FIFO:
  - Width is $clog2(NUM_REQ); read/write pointers wrap modulo TAG_DEPTH.
  - Full when count==TAG_DEPTH.
  - A push and a pop in the same cycle leave the count unchanged; push-while-full is impossible by construction.
- outstanding is the registered FIFO count.
- The multiplier must preserve beat count and tlast position per packet. The arbiter does no length checking.
- Reset mid-packet aborts everything immediately: the FIFO is flushed and in-flight multiplier results are routed nowhere, so the system must reset the multiplier together with the arbiter.
- Single-beat packets (last on the first beat) take 2 cycles per grant minimum.

Test Plan:
- Reset: after rst high 2 cycles, all valid/ready outputs are 0, outstanding=0, and no grant is issued while rst=1 despite req_valid=2'b11.
- Round-robin: both requesters continuously send 3-beat packets with an always-ready multiplier. Grants alternate 0,1,0,1, with one IDLE cycle between packets, and each packet is 3 consecutive mult_slv beats.
- Packet lock: req1 asserts valid mid-way through a 4-beat packet from req0. req1 receives no req_ready until req0's last beat is accepted, then is granted after one idle cycle.
- Response routing: a multiplier model with 5-cycle latency is fed packets from req0 (2 beats) then req1 (3 beats). rsp_valid[0] pulses for exactly 2 results and rsp_valid[1] for 3, with rsp_last on the 2nd and 5th results.
- Full / backpressure:
  - With TAG_DEPTH=2 and rsp_ready=0, after 2 single-beat packets outstanding=2 and no third grant occurs.
  - Raising rsp_ready[0] pops one tag; the third grant follows one cycle later.
- Operand stall: mult_slv_ready toggles 2'b01/2'b11. req_ready is high only when both bits are 1, and beat order and values are unchanged.
